// File: rtl/fp_div_pkg.sv
// Shared types and format-derived constants for the iterative FP divider.
package fp_div_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RDN = 2'b10,
    RM_RUP = 2'b11
  } rm_t;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUB,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } fp_class_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ITER,
    S_ROUND,
    S_DONE
  } state_t;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fp_flags_t;

  function automatic int fp_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  function automatic logic [31:0] fp_qnan(input int ew, input int mw);
    return (((32'd1 << ew) - 32'd1) << mw) | (32'd1 << (mw - 1));
  endfunction

  function automatic logic [31:0] fp_max_norm(input int ew, input int mw);
    return (((32'd1 << ew) - 32'd2) << mw) | ((32'd1 << mw) - 32'd1);
  endfunction

endpackage

// File: rtl/fp_div_unpack.sv
// Combinational operand classify; subnormals are normalised so sig always has its MSB set,
// with the exponent going to zero or negative for them.
module fp_div_unpack import fp_div_pkg::*; #(
  parameter int EXP_WIDTH = 8,
  parameter int MANT_WIDTH = 7,
  localparam int WIDTH = EXP_WIDTH + MANT_WIDTH + 1
) (
  input  logic [WIDTH-1:0]            op,
  input  logic                        ftz,
  output fp_class_t                   cls,
  output logic                        sign,
  output logic signed [EXP_WIDTH+1:0] exp,
  output logic [MANT_WIDTH:0]         sig
);

  logic [EXP_WIDTH-1:0]  e;
  logic [MANT_WIDTH-1:0] f;
  int                    lz;
  logic                  found;

  assign sign = op[WIDTH-1];
  assign e    = op[WIDTH-2:MANT_WIDTH];
  assign f    = op[MANT_WIDTH-1:0];

  always_comb begin
    lz    = 0;
    found = 1'b0;
    for (int i = MANT_WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (f[i]) found = 1'b1;
        else      lz = lz + 1;
      end
    end
  end

  always_comb begin
    cls = CLS_NORM;
    exp = $signed({2'b00, e});
    sig = {1'b1, f};
    if (e == '1) begin
      if (f == '0)              cls = CLS_INF;
      else if (f[MANT_WIDTH-1]) cls = CLS_QNAN;
      else                      cls = CLS_SNAN;
    end else if (e == '0) begin
      if (f == '0 || ftz) begin
        cls = CLS_ZERO;
      end else begin
        // value = f * 2^(1-bias-mw): shifting the leading one to the MSB costs lz+1 exponent steps
        cls = CLS_SUB;
        exp = -((EXP_WIDTH + 2)'(lz));
        sig = {1'b0, f} << (lz + 1);
      end
    end
  end

endmodule

// File: rtl/fp_div_rm.sv
// Iterative restoring FP divider with rounding modes, subnormals, IEEE flags and tag passthrough.
// One op in flight: MANT_WIDTH+5 cycles normal, 2 cycles specials; result held in DONE until ready_out.
module fp_div_rm import fp_div_pkg::*; #(
  parameter int EXP_WIDTH = 8,
  parameter int MANT_WIDTH = 7,
  parameter int TAG_WIDTH = 4,
  localparam int WIDTH = EXP_WIDTH + MANT_WIDTH + 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic [WIDTH-1:0]     operand1,
  input  logic [WIDTH-1:0]     operand2,
  input  logic [1:0]           rm,
  input  logic                 ftz_en,
  input  logic [TAG_WIDTH-1:0] tag_in,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic [WIDTH-1:0]     result,
  output logic [4:0]           flags,
  output logic [TAG_WIDTH-1:0] tag_out
);

  localparam int QW = MANT_WIDTH + 3;
  localparam int XW = EXP_WIDTH + 3;
  localparam int CW = $clog2(QW + 1);

  localparam logic [WIDTH-1:0]     QNAN    = WIDTH'(fp_qnan(EXP_WIDTH, MANT_WIDTH));
  localparam logic [WIDTH-2:0]     MAX_MAG = (WIDTH - 1)'(fp_max_norm(EXP_WIDTH, MANT_WIDTH));
  localparam logic [WIDTH-2:0]     INF_MAG = {{EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
  localparam logic signed [XW-1:0] BIAS_X  = XW'(fp_bias(EXP_WIDTH));
  localparam logic signed [XW-1:0] EMAX_X  = XW'((1 << EXP_WIDTH) - 1);
  localparam logic signed [XW-1:0] ONE_X   = XW'(1);
  localparam logic signed [XW-1:0] ZERO_X  = XW'(0);
  localparam logic [XW-1:0]        SH_MAX  = XW'(MANT_WIDTH + 2);

  state_t state, state_nxt;

  logic [WIDTH-1:0]      op1_q, op2_q;
  rm_t                   rm_q;
  logic                  ftz_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic                  sign_q;
  logic signed [XW-1:0]  exp_q;
  logic [QW-1:0]         rem_q, quo_q;
  logic [MANT_WIDTH:0]   div_q;
  logic [CW-1:0]         cnt_q;
  logic                  spec_q;
  logic [WIDTH-1:0]      spec_res_q, result_q;
  fp_flags_t             spec_fl_q, flags_q;

  fp_class_t                   cls1, cls2;
  logic                        s1, s2;
  logic signed [EXP_WIDTH+1:0] e1, e2;
  logic [MANT_WIDTH:0]         m1, m2;

  fp_div_unpack #(.EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH)) u_unpack1 (
    .op(op1_q), .ftz(ftz_q), .cls(cls1), .sign(s1), .exp(e1), .sig(m1)
  );
  fp_div_unpack #(.EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH)) u_unpack2 (
    .op(op2_q), .ftz(ftz_q), .cls(cls2), .sign(s2), .exp(e2), .sig(m2)
  );

  logic accept;
  assign ready_in  = (state == S_IDLE) && !RST;
  assign accept    = valid_in && ready_in;
  assign valid_out = (state == S_DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign tag_out   = tag_q;

  // Special-operand detection, evaluated in PRE
  logic       spec;
  logic [WIDTH-1:0] spec_res;
  fp_flags_t  spec_fl;
  logic       sgn, nan1, nan2, z1, z2, i1, i2;

  always_comb begin
    sgn      = s1 ^ s2;
    nan1     = (cls1 == CLS_QNAN) || (cls1 == CLS_SNAN);
    nan2     = (cls2 == CLS_QNAN) || (cls2 == CLS_SNAN);
    z1       = (cls1 == CLS_ZERO);
    z2       = (cls2 == CLS_ZERO);
    i1       = (cls1 == CLS_INF);
    i2       = (cls2 == CLS_INF);
    spec     = 1'b1;
    spec_res = QNAN;
    spec_fl  = '0;
    if (nan1 || nan2) begin
      spec_fl.nv = (cls1 == CLS_SNAN) || (cls2 == CLS_SNAN);
    end else if ((z1 && z2) || (i1 && i2)) begin
      spec_fl.nv = 1'b1;
    end else if (i1) begin
      spec_res = {sgn, INF_MAG};
    end else if (z2) begin
      spec_res   = {sgn, INF_MAG};
      spec_fl.dz = 1'b1;
    end else if (i2 || z1) begin
      spec_res = {sgn, {(WIDTH-1){1'b0}}};
    end else begin
      spec = 1'b0;
    end
  end

  logic                 lt;
  logic signed [XW-1:0] exp_pre;
  logic                 ge;
  logic [QW-1:0]        diff, rem_nxt;

  always_comb begin
    lt      = (m1 < m2);
    exp_pre = XW'(e1) - XW'(e2) + BIAS_X - (lt ? ONE_X : ZERO_X);
    ge      = (rem_q >= {2'b00, div_q});
    diff    = rem_q - {2'b00, div_q};
    rem_nxt = ge ? diff : rem_q;
  end

  // Rounding: subnormal and normal results share one {exp,frac}+inc adder so carries cross naturally
  logic                  tiny, pre_ovf, ovf, inexact, inc, g, r, st, sticky0;
  logic [XW-1:0]         shamt;
  logic [QW-1:0]         mask;
  logic [QW-2:0]         m_d;
  logic [EXP_WIDTH-1:0]  efield;
  logic [MANT_WIDTH-1:0] frac;
  logic [WIDTH-2:0]      sum;
  logic [WIDTH-1:0]      rnd_res;
  fp_flags_t             rnd_fl;

  always_comb begin
    sticky0 = |rem_q;
    tiny    = (exp_q <= ZERO_X);
    pre_ovf = (exp_q >= EMAX_X);
    shamt   = ONE_X - exp_q;
    mask    = ~({QW{1'b1}} << shamt);
    m_d     = (QW - 1)'(quo_q >> shamt);
    efield  = exp_q[EXP_WIDTH-1:0];
    frac    = quo_q[QW-2:2];
    g       = quo_q[1];
    r       = quo_q[0];
    st      = sticky0;
    if (tiny && !ftz_q) begin
      efield = '0;
      if (shamt >= SH_MAX) begin
        frac = '0;
        g    = 1'b0;
        r    = 1'b0;
        st   = sticky0 | (|quo_q);
      end else begin
        frac = m_d[QW-2:2];
        g    = m_d[1];
        r    = m_d[0];
        st   = sticky0 | (|(quo_q & mask));
      end
    end
    inexact = g | r | st;
    case (rm_q)
      RM_RNE:  inc = g & (r | st | frac[0]);
      RM_RDN:  inc = sign_q & inexact;
      RM_RUP:  inc = !sign_q & inexact;
      default: inc = 1'b0;
    endcase
    sum = {efield, frac} + {{(WIDTH-2){1'b0}}, inc};
    ovf = !tiny && (pre_ovf || (sum[WIDTH-2:MANT_WIDTH] == '1));

    rnd_fl = '0;
    if (tiny && ftz_q) begin
      rnd_res   = {sign_q, {(WIDTH-1){1'b0}}};
      rnd_fl.uf = 1'b1;
      rnd_fl.nx = 1'b1;
    end else if (ovf) begin
      case (rm_q)
        RM_RTZ:  rnd_res = {sign_q, MAX_MAG};
        RM_RDN:  rnd_res = {sign_q, sign_q ? INF_MAG : MAX_MAG};
        RM_RUP:  rnd_res = {sign_q, sign_q ? MAX_MAG : INF_MAG};
        default: rnd_res = {sign_q, INF_MAG};
      endcase
      rnd_fl.of = 1'b1;
      rnd_fl.nx = 1'b1;
    end else begin
      rnd_res   = {sign_q, sum};
      rnd_fl.uf = tiny & inexact;
      rnd_fl.nx = inexact;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_PRE;
      S_PRE:   state_nxt = spec ? S_ROUND : S_ITER;
      S_ITER:  if (cnt_q == CW'(QW - 1)) state_nxt = S_ROUND;
      S_ROUND: state_nxt = S_DONE;
      S_DONE:  if (ready_out) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      op1_q      <= '0;
      op2_q      <= '0;
      rm_q       <= RM_RNE;
      ftz_q      <= 1'b0;
      tag_q      <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_fl_q  <= '0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (accept) begin
          op1_q <= operand1;
          op2_q <= operand2;
          rm_q  <= rm_t'(rm);
          ftz_q <= ftz_en;
          tag_q <= tag_in;
        end
        S_PRE: begin
          spec_q     <= spec;
          spec_res_q <= spec_res;
          spec_fl_q  <= spec_fl;
          sign_q     <= sgn;
          exp_q      <= exp_pre;
          rem_q      <= lt ? {1'b0, m1, 1'b0} : {2'b00, m1};
          div_q      <= m2;
          quo_q      <= '0;
          cnt_q      <= '0;
        end
        S_ITER: begin
          rem_q <= {rem_nxt[QW-2:0], 1'b0};
          quo_q <= {quo_q[QW-2:0], ge};
          cnt_q <= cnt_q + CW'(1);
        end
        S_ROUND: begin
          result_q <= spec_q ? spec_res_q : rnd_res;
          flags_q  <= spec_q ? spec_fl_q : rnd_fl;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fp_div_rm.md
Name: fp_div_rm

Overview:
- Iterative IEEE-style floating-point divider, parametrised in exponent and mantissa width (FP16, BF16, custom formats).
- Next generation of the vector-unit divider. Adds per-operation rounding mode, gradual-subnormal support (flush-to-zero becomes a runtime mode), IEEE exception flags and a passthrough tag.
- Single operation in flight; valid/ready handshake on both sides.
- Sits in the vector datapath beside the FP add/mul units.

Parameters:
- EXP_WIDTH, 8, exponent field width (5 for FP16, 8 for BF16).
- MANT_WIDTH, 7, stored fraction width (10 for FP16, 7 for BF16).
- TAG_WIDTH, 4, width of the opaque tag carried from input to output.
- WIDTH, EXP_WIDTH+MANT_WIDTH+1, derived operand width; not overridable.

Ports:
- CLK  in  1  clock, all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- valid_in  in  1  input operation valid.
- ready_in  out  1  divider can accept an operation.
- operand1  in  WIDTH  dividend.
- operand2  in  WIDTH  divisor.
- rm  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN, 11 RUP.
- ftz_en  in  1  1 = subnormal inputs treated as zero and subnormal results flushed to signed zero.
- tag_in  in  TAG_WIDTH  user tag.
- valid_out  out  1  result valid.
- ready_out  in  1  consumer accepts result.
- result  out  WIDTH  quotient.
- flags  out  5  {NV, DZ, OF, UF, NX}.
- tag_out  out  TAG_WIDTH  tag of the operation.

Behaviour:
- Reset (RST high at an edge): state IDLE; ready_in=0, valid_out=0, result=0, flags=0, tag_out=0.
  - ready_in is also gated by RST combinationally, so it is 0 in every cycle RST is high.
  - RST mid-operation abandons the operation; no stale output ever appears.
- FSM IDLE -> PRE -> ITER -> ROUND -> DONE -> IDLE.
  - ready_in = (state==IDLE) && !RST.
  - Accept on valid_in && ready_in: latch operands, rm, ftz_en and tag.
- PRE (1 cycle):
  - Unpack and classify each operand: zero, subnormal, normal, inf, qNaN, sNaN.
  - ftz_en=0: subnormals are normalised with a leading-zero count into a signed (EXP_WIDTH+2)-bit exponent.
  - Special cases go straight to DONE:
    - any NaN -> canonical qNaN {0, all-ones exp, 1, 0...}; NV only if an input is sNaN.
    - 0/0 and inf/inf -> qNaN with NV.
    - finite nonzero / 0 -> signed inf with DZ.
    - inf/x -> signed inf.
    - x/inf and 0/x -> signed zero.
- ITER:
  - Restoring radix-2 division, one quotient bit per cycle, MANT_WIDTH+3 cycles.
  - Bits produced: integer bit, fraction bits, guard, round; sticky = remainder != 0.
  - Result sign = s1 XOR s2. Exponent = e1 - e2 + bias. If dividend significand < divisor significand, pre-shift the dividend left by one and decrement the exponent.
- ROUND (1 cycle):
  - Exponent <= 0 and ftz_en=0: right-shift to denormalise, ORing shifted-out bits into sticky. A shift of MANT_WIDTH+2 or more leaves sticky only.
  - Rounding per rm. A mantissa carry-out increments the exponent; a subnormal rounding up to min-normal becomes min-normal.
  - Overflow (exponent >= all-ones): RNE -> inf; RTZ -> max-norm; RDN -> +max-norm / -inf; RUP -> +inf / -max-norm. OF and NX set.
  - UF = tiny before rounding AND inexact.
  - ftz_en=1 with a tiny result -> signed zero, UF and NX set.
  - NX = any discarded bit nonzero.
- Latency:
  - Normal path: accept at edge N, valid_out high after edge N+MANT_WIDTH+5.
  - Special path: valid_out high after edge N+2.
- DONE: valid_out=1. result, flags and tag_out are held stable until ready_out is sampled high. Then go to IDLE; ready_in rises the cycle after.
  - No accept occurs in the same cycle as the output transfer.
  - ready_out high before DONE has no effect.

Decomposition:
- fp_div_pkg holds:
  - rm_t enum.
  - fp_class_t enum (ZERO, SUB, NORM, INF, QNAN, SNAN).
  - state_t enum.
  - fp_flags_t packed struct {nv, dz, of, uf, nx}.
  - Functions deriving BIAS, QNAN and MAX_NORM from the width parameters.
- Sub-module fp_div_unpack: combinational classify plus LZC normalisation, instantiated once per operand.

Test Plan:
- BF16, rm=RNE: 3F80/4040 -> 3EAB, flags NX. Same with rm=RTZ -> 3EAA. 3F80/4000 -> 3F00, flags 0, latency exactly MANT_WIDTH+5.
- ftz_en=0: 0001/3F80 -> 0001, flags 0. 0001/4000 with RNE -> 0000, UF NX; with RUP -> 0001, UF NX. ftz_en=1: 0001/3F80 -> 0000.
- Overflow: 7F7F/3F00 with RNE -> 7F80, OF NX; RTZ -> 7F7F; FF7F/3F00 with RUP -> FF7F.
- Specials: 0000/0000 -> 7FC0 NV; 3F80/0000 -> 7F80 DZ; 7F81/3F80 -> 7FC0 NV; 7FC0/3F80 -> 7FC0, flags 0. Each has latency 2 and tag_out = tag_in.
- Backpressure: hold ready_out low for 5 cycles in DONE -> valid_out, result, flags and tag_out stable; ready_in stays 0; a valid_in offered meanwhile is not accepted.
- Reset: ready_in=0 and valid_out=0 while RST high. RST pulsed during ITER -> next cycle valid_out=0. After release, ready_in=1 and a fresh 3F80/4000 returns 3F00 with the correct tag.
